pci_arbiter: RTL and testbench

PCI_ARBITER -- requirements
Module: pci_arbiter

---
 rtl/pci_pkg.sv | 25 ++
 rtl/pci_arbiter_rr_pick.sv | 29 ++
 rtl/pci_arbiter.sv | 132 +++++++++++++
 tb/tb_pci_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// Shared definitions for the PCI arbiter: FSM states, parameter defaults and width helpers.
package pci_pkg;

  localparam int unsigned N_MASTERS_DEF   = 4;
  localparam int unsigned GNT_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_TURN  = 2'd3
  } arb_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Timeout counter is at least 4 bits and wide enough to hold the timeout value.
  function automatic int unsigned cnt_w(input int unsigned t);
    int unsigned w;
    w = $clog2(t + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/pci_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request at or after the pointer, wrapping.
module rr_pick
  import pci_pkg::*;
#(
  parameter int unsigned N  = N_MASTERS_DEF,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx_c,
  output logic          o_valid_c
);

  logic [IW-1:0] w_cand;

  always_comb begin
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_cand = IW'((32'(i_ptr) + k) % N);
      if (!o_valid_c && i_req[w_cand]) begin
        o_valid_c = 1'b1;
        o_idx_c   = w_cand;
      end
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// PCI bus arbiter: round-robin grant, grant timeout, pre-emption while busy, one-cycle turnaround.
module pci_arbiter
  import pci_pkg::*;
#(
  parameter int unsigned N_MASTERS   = N_MASTERS_DEF,
  parameter int unsigned GNT_TIMEOUT = GNT_TIMEOUT_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_MASTERS-1:0] REQ,
  input  logic                 FRAME,
  input  logic                 IRDY,
  output logic [N_MASTERS-1:0] GNT,
  output logic [1:0]           OWNER,
  output logic                 BUS_BUSY
);

  localparam int unsigned IDX_W = idx_w(N_MASTERS);
  localparam int unsigned CNT_W = cnt_w(GNT_TIMEOUT);

  arb_state_e           r_state, w_state_nxt;
  logic [N_MASTERS-1:0] r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0]     r_owner, w_owner_nxt;
  logic [IDX_W-1:0]     r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 r_bus_busy;

  logic [N_MASTERS-1:0] w_req_act;
  logic [N_MASTERS-1:0] w_owner_mask;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_valid;
  logic [IDX_W-1:0]     w_ptr_inc;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 w_bus_idle;
  logic                 w_other_req;

  // Active-high request view; anything other than a clean 0 counts as not requesting.
  always_comb begin
    w_req_act = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      w_req_act[i] = (REQ[i] === 1'b0);
    end
  end

  rr_pick #(
    .N  (N_MASTERS),
    .IW (IDX_W)
  ) u_rr_pick (
    .i_req     (w_req_act),
    .i_ptr     (r_ptr),
    .o_idx_c   (w_pick_idx),
    .o_valid_c (w_pick_valid)
  );

  assign w_bus_idle   = FRAME & IRDY;
  assign w_owner_mask = N_MASTERS'(1) << r_owner;
  assign w_other_req  = |(w_req_act & ~w_owner_mask);
  assign w_ptr_inc    = (w_pick_idx == IDX_W'(N_MASTERS - 1)) ? '0 : w_pick_idx + IDX_W'(1);
  assign w_cnt_inc    = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '1;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_bus_busy <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bus_busy <= ~w_bus_idle;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = '0;
    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = '1;
        if (w_pick_valid) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = ~(N_MASTERS'(1) << w_pick_idx);
          w_owner_nxt = w_pick_idx;
          w_ptr_nxt   = w_ptr_inc;
        end
      end
      ST_GRANT: begin
        if (!FRAME) begin
          w_state_nxt = ST_BUSY;
        end else if (!w_req_act[r_owner]) begin
          w_state_nxt = ST_TURN;
          w_gnt_nxt   = '1;
        end else if (w_cnt_inc >= CNT_W'(GNT_TIMEOUT)) begin
          w_state_nxt = ST_TURN;
          w_gnt_nxt   = '1;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_BUSY: begin
        // A competing request only withdraws the grant; the transfer runs to bus idle.
        if (w_bus_idle) begin
          w_state_nxt = ST_TURN;
          w_gnt_nxt   = '1;
        end else if (w_other_req) begin
          w_gnt_nxt = '1;
        end
      end
      ST_TURN: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '1;
      end
    endcase
  end

  assign GNT      = r_gnt;
  assign OWNER    = 2'(r_owner);
  assign BUS_BUSY = r_bus_busy;

endmodule

// File: tb/tb_pci_arbiter.sv
// Bench for pci_arbiter: directed vector table plus a random run checked against a reference model.
module tb_pci_arbiter;
  import pci_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] REQ;
  logic       FRAME;
  logic       IRDY;
  logic [3:0] GNT;
  logic [1:0] OWNER;
  logic       BUS_BUSY;

  always #5 CLK = ~CLK;

  pci_arbiter #(
    .N_MASTERS   (4),
    .GNT_TIMEOUT (16)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .FRAME    (FRAME),
    .IRDY     (IRDY),
    .GNT      (GNT),
    .OWNER    (OWNER),
    .BUS_BUSY (BUS_BUSY)
  );

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    logic       frame;
    logic       irdy;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t       tbl[$];
  vec_t       expq[$];
  int         checks   = 0;
  int         failures = 0;
  int         step_no  = 0;
  logic [3:0] prev_gnt = 4'hF;

  // Reference model state
  int         m_state = 0;
  logic [3:0] m_gnt   = 4'hF;
  logic [1:0] m_owner = 2'd0;
  logic [1:0] m_ptr   = 2'd0;
  int         m_cnt   = 0;
  logic       m_busy  = 1'b0;

  function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic frame,
                              input logic irdy, input logic [3:0] gnt, input logic [1:0] owner,
                              input logic busy);
    vec_t v;
    v.rst = rst; v.req = req; v.frame = frame; v.irdy = irdy;
    v.gnt = gnt; v.owner = owner; v.busy = busy;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, step_no, got, want);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    RST   = v.rst;
    REQ   = v.req;
    FRAME = v.frame;
    IRDY  = v.irdy;
    expq.push_back(v);
    @(posedge CLK);
    #1;
    e = expq.pop_front();
    cmp("gnt", 32'(GNT), 32'(e.gnt));
    cmp("owner", 32'(OWNER), 32'(e.owner));
    cmp("bus_busy", 32'(BUS_BUSY), 32'(e.busy));
    cmp("gnt_onehot", 32'($countones(~GNT) <= 1), 32'd1);
    cmp("gnt_gap", 32'(!(prev_gnt != 4'hF && GNT != 4'hF && GNT != prev_gnt)), 32'd1);
    prev_gnt = GNT;
    step_no++;
  endtask

  task automatic model_step(input logic rst, input logic [3:0] req, input logic frame,
                            input logic irdy);
    logic       found;
    logic [1:0] idx;
    logic [1:0] w;
    if (rst) begin
      m_state = 0; m_gnt = 4'hF; m_owner = 2'd0; m_ptr = 2'd0; m_cnt = 0; m_busy = 1'b0;
    end else begin
      m_busy = !(frame && irdy);
      case (m_state)
        0: begin
          m_gnt = 4'hF;
          found = 1'b0;
          w     = 2'd0;
          for (int k = 0; k < 4; k++) begin
            idx = m_ptr + 2'(k);
            if (!found && req[idx] == 1'b0) begin
              found = 1'b1;
              w     = idx;
            end
          end
          if (found) begin
            m_gnt[w] = 1'b0;
            m_owner  = w;
            m_ptr    = w + 2'd1;
            m_cnt    = 0;
            m_state  = 1;
          end
        end
        1: begin
          if (!frame) begin
            m_state = 2; m_cnt = 0;
          end else if (req[m_owner]) begin
            m_gnt = 4'hF; m_state = 3; m_cnt = 0;
          end else if (m_cnt + 1 >= int'(GNT_TIMEOUT_DEF)) begin
            m_gnt = 4'hF; m_state = 3; m_cnt = 0;
          end else begin
            m_cnt = m_cnt + 1;
          end
        end
        2: begin
          if (frame && irdy) begin
            m_gnt = 4'hF; m_state = 3;
          end else begin
            for (int i = 0; i < 4; i++) begin
              if (2'(i) != m_owner && req[i] == 1'b0) m_gnt = 4'hF;
            end
          end
        end
        default: begin
          m_gnt = 4'hF; m_state = 0;
        end
      endcase
    end
  endtask

  initial begin
    logic [3:0] r_req;
    logic       r_frame;
    logic       r_irdy;
    logic       r_rst;
    int         mode;

    RST = 1'b1; REQ = 4'hF; FRAME = 1'b1; IRDY = 1'b1;

    // rst, req, frame, irdy -> gnt, owner, busy (values after the edge)
    tbl.push_back(mk(1, 4'b1111, 1, 1, 4'b1111, 2'd0, 0));
    tbl.push_back(mk(0, 4'b1110, 1, 1, 4'b1110, 2'd0, 0));
    tbl.push_back(mk(0, 4'b1110, 0, 1, 4'b1110, 2'd0, 1));
    tbl.push_back(mk(0, 4'b1111, 1, 0, 4'b1110, 2'd0, 1));
    tbl.push_back(mk(0, 4'b1111, 1, 1, 4'b1111, 2'd0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 4'b1111, 2'd0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 4'b1101, 2'd1, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 4'b1101, 2'd1, 1));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 4'b1111, 2'd1, 1));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 4'b1111, 2'd1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 4'b1111, 2'd1, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 4'b1011, 2'd2, 0));
    // Master 2 holds the grant with FRAME high until the timeout; master 3 waits.
    for (int i = 1; i < 16; i++) tbl.push_back(mk(0, 4'b0011, 1, 1, 4'b1011, 2'd2, 0));
    tbl.push_back(mk(0, 4'b0011, 1, 1, 4'b1111, 2'd2, 0));
    tbl.push_back(mk(0, 4'b0011, 1, 1, 4'b1111, 2'd2, 0));
    tbl.push_back(mk(0, 4'b0011, 1, 1, 4'b0111, 2'd3, 0));
    // Owner drops its request, then master 0 is pre-empted by master 3 during BUSY.
    tbl.push_back(mk(0, 4'b1111, 1, 1, 4'b1111, 2'd3, 0));
    tbl.push_back(mk(0, 4'b1111, 1, 1, 4'b1111, 2'd3, 0));
    tbl.push_back(mk(0, 4'b1110, 1, 1, 4'b1110, 2'd0, 0));
    tbl.push_back(mk(0, 4'b1110, 0, 1, 4'b1110, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0110, 0, 1, 4'b1111, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0110, 0, 0, 4'b1111, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0110, 1, 0, 4'b1111, 2'd0, 1));
    tbl.push_back(mk(0, 4'b0110, 1, 1, 4'b1111, 2'd0, 0));
    tbl.push_back(mk(0, 4'b0110, 1, 1, 4'b1111, 2'd0, 0));
    tbl.push_back(mk(0, 4'b0110, 1, 1, 4'b0111, 2'd3, 0));
    // Reset during BUSY, then first grant straight out of reset goes to the lowest requester.
    tbl.push_back(mk(0, 4'b0110, 0, 1, 4'b0111, 2'd3, 1));
    tbl.push_back(mk(1, 4'b0110, 0, 1, 4'b1111, 2'd0, 0));
    tbl.push_back(mk(0, 4'b0101, 1, 1, 4'b1101, 2'd1, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Random traffic against the reference model
    model_step(1'b1, 4'hF, 1'b1, 1'b1);
    apply(mk(1, 4'hF, 1, 1, m_gnt, m_owner, m_busy));
    r_req = 4'hF;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      mode = (cyc / 250) % 2;
      if ($urandom_range(0, 1) == 0) begin
        for (int b = 0; b < 4; b++) r_req[b] = ($urandom_range(0, 2) != 0);
      end
      if (mode == 0) r_frame = ($urandom_range(0, 1) == 0);
      else           r_frame = ($urandom_range(0, 39) != 0);
      r_irdy = ($urandom_range(0, 3) != 0);
      r_rst  = ($urandom_range(0, 999) == 0);
      model_step(r_rst, r_req, r_frame, r_irdy);
      apply(mk(r_rst, r_req, r_frame, r_irdy, m_gnt, m_owner, m_busy));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
